serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder_2.sv | 13 +
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_2.sv
// Single-bit full-adder cell used as the bit slice of the serial adder.
module full_adder_2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB first over WIDTH cycles.
// Optional subtraction (sub port) is built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  full_adder_2 u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_co)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // a - b computed as a + ~b + 1; cout=1 then means no borrow
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          // new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
          r_sum   <= (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
          if (w_last) r_cout <= w_co;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
